sm3_msg_pack: RTL and testbench

SM3_MSG_PACK -- requirements
Module: sm3_msg_pack

---
 rtl/sm3_msg_pack.sv | 165 ++++++++++++++++
 tb/tb_sm3_msg_pack.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_pack.sv
// sm3_msg_pack: packs a byte stream MSB-first into DW-bit words for the SM3
// core message input. A single accumulator feeds one output register. A
// completed word skips straight into the output register when that register
// can load; otherwise it waits in the accumulator and byte intake stalls.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   byte_i          message byte
//   byte_vld_i      byte_i valid
//   byte_lst_i      byte_i is the final byte of the message
//   byte_rdy_o      byte accepted this cycle when byte_vld_i is high
//   msg_d_o         packed word, first byte in bits [DW-1:DW-8]
//   msg_vld_byte_o  lane-valid mask, bit NB-1 maps to the top byte
//   msg_vld_o       word valid
//   msg_lst_o       word carries the last byte of the message
//   msg_rdy_i       downstream accepts the word
//   byte_cnt_o      bytes accepted in the current message
module sm3_msg_pack #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    byte_i,
    input  logic          byte_vld_i,
    input  logic          byte_lst_i,
    output logic          byte_rdy_o,
    output logic [DW-1:0] msg_d_o,
    output logic [DW/8-1:0] msg_vld_byte_o,
    output logic          msg_vld_o,
    output logic          msg_lst_o,
    input  logic          msg_rdy_i,
    output logic [60:0]   byte_cnt_o
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW = 61;
    localparam logic [LW-1:0] LANE_TOP = LW'(NB - 1);

    logic [DW-1:0] acc_q, acc_d;
    logic [NB-1:0] acc_mask_q, acc_mask_d;
    logic          acc_lst_q, acc_lst_d;
    logic          acc_full_q, acc_full_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [DW-1:0] out_q, out_d;
    logic [NB-1:0] out_mask_q, out_mask_d;
    logic          out_lst_q, out_lst_d;
    logic          out_vld_q, out_vld_d;
    logic          rdy_q, rdy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          restart_q, restart_d;

    logic          accept;
    logic          complete;
    logic          out_can_load;
    logic [DW-1:0] word_nxt;
    logic [NB-1:0] mask_nxt;

    // Handshake and completion terms
    assign accept       = byte_vld_i && rdy_q;
    assign complete     = (lane_q == '0) || byte_lst_i;
    assign out_can_load = !out_vld_q || msg_rdy_i;
    assign word_nxt     = acc_q | (DW'(byte_i) << {lane_q, 3'b000});
    assign mask_nxt     = acc_mask_q | (NB'(1) << lane_q);

    // Next-state logic for accumulator, output register and byte counter
    always_comb begin
        acc_d      = acc_q;
        acc_mask_d = acc_mask_q;
        acc_lst_d  = acc_lst_q;
        acc_full_d = acc_full_q;
        lane_d     = lane_q;
        out_d      = out_q;
        out_mask_d = out_mask_q;
        out_lst_d  = out_lst_q;
        out_vld_d  = out_vld_q;
        cnt_d      = cnt_q;
        restart_d  = restart_q;

        if (out_vld_q && msg_rdy_i) begin
            out_vld_d = 1'b0;
        end

        // A word parked in the accumulator moves out as soon as out frees up
        if (acc_full_q && out_can_load) begin
            out_d      = acc_q;
            out_mask_d = acc_mask_q;
            out_lst_d  = acc_lst_q;
            out_vld_d  = 1'b1;
            acc_d      = '0;
            acc_mask_d = '0;
            acc_lst_d  = 1'b0;
            acc_full_d = 1'b0;
        end

        // accept is never true while acc_full_q is set, so no conflict above
        if (accept) begin
            cnt_d     = restart_q ? CW'(1) : cnt_q + CW'(1);
            restart_d = byte_lst_i;
            if (complete) begin
                lane_d = LANE_TOP;
                if (out_can_load) begin
                    out_d      = word_nxt;
                    out_mask_d = mask_nxt;
                    out_lst_d  = byte_lst_i;
                    out_vld_d  = 1'b1;
                    acc_d      = '0;
                    acc_mask_d = '0;
                    acc_lst_d  = 1'b0;
                end else begin
                    acc_d      = word_nxt;
                    acc_mask_d = mask_nxt;
                    acc_lst_d  = byte_lst_i;
                    acc_full_d = 1'b1;
                end
            end else begin
                acc_d      = word_nxt;
                acc_mask_d = mask_nxt;
                lane_d     = lane_q - LW'(1);
            end
        end
    end

    // Ready is registered so msg_rdy_i has no combinational path to it
    assign rdy_d = !acc_full_d;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            acc_mask_q <= '0;
            acc_lst_q  <= 1'b0;
            acc_full_q <= 1'b0;
            lane_q     <= LANE_TOP;
            out_q      <= '0;
            out_mask_q <= '0;
            out_lst_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
            restart_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_mask_q <= acc_mask_d;
            acc_lst_q  <= acc_lst_d;
            acc_full_q <= acc_full_d;
            lane_q     <= lane_d;
            out_q      <= out_d;
            out_mask_q <= out_mask_d;
            out_lst_q  <= out_lst_d;
            out_vld_q  <= out_vld_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
            restart_q  <= restart_d;
        end
    end

    assign byte_rdy_o     = rdy_q;
    assign msg_d_o        = out_q;
    assign msg_vld_byte_o = out_mask_q;
    assign msg_vld_o      = out_vld_q;
    assign msg_lst_o      = out_lst_q;
    assign byte_cnt_o     = cnt_q;

endmodule

// File: tb/tb_sm3_msg_pack.sv
// tb_sm3_msg_pack: directed and randomized byte streams into a 32-bit and a
// 64-bit instance of sm3_msg_pack. Expected words come from a message-level
// model that chunks accepted bytes into NB-byte words with zero padding.
module tb_sm3_msg_pack;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_i;
    logic        byte_vld_i;
    logic        byte_lst_i;
    logic        msg_rdy_i;

    logic        rdy32, vld32, lst32;
    logic [31:0] d32;
    logic [3:0]  m32;
    logic [60:0] cnt32;
    logic        rdy64, vld64, lst64;
    logic [63:0] d64;
    logic [7:0]  m64;
    logic [60:0] cnt64;

    sm3_msg_pack #(.DW(32)) u_dut32 (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_vld_i(byte_vld_i),
        .byte_lst_i(byte_lst_i), .byte_rdy_o(rdy32), .msg_d_o(d32),
        .msg_vld_byte_o(m32), .msg_vld_o(vld32), .msg_lst_o(lst32),
        .msg_rdy_i(msg_rdy_i), .byte_cnt_o(cnt32)
    );

    sm3_msg_pack #(.DW(64)) u_dut64 (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_vld_i(byte_vld_i),
        .byte_lst_i(byte_lst_i), .byte_rdy_o(rdy64), .msg_d_o(d64),
        .msg_vld_byte_o(m64), .msg_vld_o(vld64), .msg_lst_o(lst64),
        .msg_rdy_i(msg_rdy_i), .byte_cnt_o(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs of whichever instance is under test
    bit          sel64;
    logic [63:0] o_d;
    logic [7:0]  o_m;
    logic        o_vld, o_lst, o_rdy;
    logic [60:0] o_cnt;

    always_comb begin
        if (sel64) begin
            o_d = d64; o_m = m64; o_vld = vld64; o_lst = lst64;
            o_rdy = rdy64; o_cnt = cnt64;
        end else begin
            o_d = {32'h0, d32}; o_m = {4'h0, m32}; o_vld = vld32;
            o_lst = lst32; o_rdy = rdy32; o_cnt = cnt32;
        end
    end

    typedef struct {
        logic [63:0] d;
        logic [7:0]  m;
        logic        l;
    } word_t;

    int          ncmp;
    int          nfail;
    int          nb;
    bit          rdy_rand;
    word_t       expq[$];
    logic [7:0]  pend[$];
    logic [60:0] mcnt;
    bit          mstart;
    bit          hold;
    logic [63:0] hd;
    logic [7:0]  hm;
    logic        hl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        pend.delete();
        mcnt   = '0;
        mstart = 1'b0;
        hold   = 1'b0;
    endtask

    // Message-level model: a word closes every NB bytes or at the last byte
    task automatic model_accept(input logic [7:0] b, input logic l);
        word_t w;
        pend.push_back(b);
        mcnt   = mstart ? 61'd1 : mcnt + 61'd1;
        mstart = l;
        if (pend.size() == nb || l) begin
            w.d = '0;
            w.m = '0;
            w.l = l;
            for (int j = 0; j < pend.size(); j++) begin
                w.d = w.d | (64'(pend[j]) << (8 * (nb - 1 - j)));
                w.m[nb - 1 - j] = 1'b1;
            end
            expq.push_back(w);
            pend.delete();
        end
    endtask

    // One clock: inputs already set at the current falling edge
    task automatic cyc();
        word_t w;
        bit    has;
        if (hold) begin
            chk1("hold_vld", o_vld, 1'b1);
            chk("hold_d", o_d, hd);
            chk("hold_mask", 64'(o_m), 64'(hm));
            chk1("hold_lst", o_lst, hl);
        end
        if (rdy_rand) msg_rdy_i = 1'($urandom_range(0, 1));
        if (byte_vld_i && o_rdy) model_accept(byte_i, byte_lst_i);
        if (o_vld && msg_rdy_i) begin
            has = (expq.size() != 0);
            chk1("word_expected", has, 1'b1);
            if (has) begin
                w = expq.pop_front();
                chk("word_d", o_d, w.d);
                chk("word_mask", 64'(o_m), 64'(w.m));
                chk1("word_lst", o_lst, w.l);
            end
        end
        hold = o_vld && !msg_rdy_i;
        hd = o_d; hm = o_m; hl = o_lst;
        @(negedge clk);
        chk("byte_cnt", 64'(o_cnt), 64'(mcnt));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        bit acc;
        byte_i     = b;
        byte_lst_i = l;
        byte_vld_i = 1'b1;
        acc        = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = o_rdy;
            cyc();
        end
        chk1("accept_in_time", acc, 1'b1);
        byte_vld_i = 1'b0;
        byte_lst_i = 1'b0;
    endtask

    // Idle cycles; byte_lst_i toggles without byte_vld_i and must be ignored
    task automatic idle(input int n);
        byte_vld_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            byte_lst_i = 1'($urandom_range(0, 1));
            cyc();
        end
        byte_lst_i = 1'b0;
    endtask

    task automatic drain();
        rdy_rand   = 1'b0;
        msg_rdy_i  = 1'b1;
        byte_vld_i = 1'b0;
        for (int i = 0; i < 60 && (expq.size() != 0 || o_vld); i++) cyc();
        chk("drain_queue", 64'(expq.size()), 64'd0);
        chk1("drain_vld", o_vld, 1'b0);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        byte_vld_i = 1'b0;
        byte_lst_i = 1'b0;
        @(negedge clk);
        chk1("rst_vld", o_vld, 1'b0);
        chk1("rst_lst", o_lst, 1'b0);
        chk("rst_d", o_d, 64'd0);
        chk("rst_mask", 64'(o_m), 64'd0);
        chk("rst_cnt", 64'(o_cnt), 64'd0);
        chk1("rst_rdy", o_rdy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk1("rdy_after_rst", o_rdy, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1'b1; byte_i = '0; byte_vld_i = 1'b0; byte_lst_i = 1'b0;
        msg_rdy_i = 1'b1; sel64 = 1'b0; nb = 4; rdy_rand = 1'b0;
        ncmp = 0; nfail = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // "abc": word appears one cycle after the last byte
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        chk1("abc_vld", o_vld, 1'b1);
        chk("abc_d", o_d, 64'h61626300);
        chk("abc_mask", 64'(o_m), 64'hE);
        chk1("abc_lst", o_lst, 1'b1);
        chk("abc_cnt", 64'(o_cnt), 64'd3);
        drain();

        // Eight bytes back-to-back, intake never stalls
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), i == 7);
            chk1("stream_rdy", o_rdy, 1'b1);
        end
        drain();

        // Downstream stalled: second word parks in the accumulator
        msg_rdy_i = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'(8'h10 * i + i), 1'b0);
        chk1("stall_rdy_low", o_rdy, 1'b0);
        idle(3);
        chk1("stall_rdy_still_low", o_rdy, 1'b0);
        msg_rdy_i = 1'b1;
        for (int i = 9; i <= 12; i++) send_byte(8'(8'h10 * i + i), i == 12);
        drain();

        // Single-byte message
        send_byte(8'hAB, 1'b1);
        chk("single_d", o_d, 64'hAB000000);
        chk("single_mask", 64'(o_m), 64'h8);
        chk1("single_lst", o_lst, 1'b1);
        drain();

        // Reset in the middle of a message discards the partial bytes
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        apply_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        chk("after_rst_d", o_d, 64'h11223344);
        chk("after_rst_mask", 64'(o_m), 64'hF);
        chk1("after_rst_lst", o_lst, 1'b1);
        drain();

        // Random messages, gaps and downstream backpressure
        rdy_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            len = $urandom_range(1, 11);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_byte(8'($urandom), j == len - 1);
            end
        end
        drain();

        // 64-bit instance: 64-byte message then the start of the next one
        sel64 = 1'b1;
        nb    = 8;
        apply_reset();
        rdy_rand = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'($urandom), i == 63);
        chk("cnt64", 64'(o_cnt), 64'd64);
        drain();
        send_byte(8'h5A, 1'b0);
        chk("cnt_restart", 64'(o_cnt), 64'd1);
        idle(2);
        chk1("partial_not_emitted", o_vld, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
